// File: rtl/switch_csr_ctrl.sv
// switch_csr_ctrl: Avalon-MM CSR front end for the FPGA switch.
// Software stages packet metadata (SRC/DEST/LEN) and pushes it into a
// show-ahead command FIFO that drains to the packet generator over
// valid/ready. Per-port saturating delivered-packet counters are read
// back through a 16-bit snapshot latched by a CNT_SEL write.
// Optional feature: define SWITCH_CSR_IRQ_EN to add IRQ_STAT (9),
// IRQ_MASK (10) and the registered irq output.
module switch_csr_ctrl #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic                          read,
  input  logic [3:0]                    address,
  input  logic [7:0]                    writedata,
  output logic [7:0]                    readdata,
  output logic                          gen_valid,
  input  logic                          gen_ready,
  output logic [$clog2(NUM_PORTS)-1:0]  gen_src,
  output logic [$clog2(NUM_PORTS)-1:0]  gen_dest,
  output logic [LEN_W-1:0]              gen_len,
  input  logic [NUM_PORTS-1:0]          pkt_done
`ifdef SWITCH_CSR_IRQ_EN
  , output logic                        irq
`endif
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic              enable_q;
  logic [PORT_W-1:0] src_q, dest_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovf_q;
  logic [7:0]        cnt_sel_q;
  logic [15:0]       snap_q;
  logic [15:0]       cnt_q [NUM_PORTS];

  logic [PORT_W-1:0] mem_src  [FIFO_DEPTH];
  logic [PORT_W-1:0] mem_dest [FIFO_DEPTH];
  logic [LEN_W-1:0]  mem_len  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_nxt;

  logic       wr_en, rd_en, clr_cnt, push_req, push_ok, pop, ovf_clr;
  logic       empty, full, sat_any;
  logic [4:0] count5;
  logic [3:0] level4;
  logic [7:0] rd_mux;

  assign wr_en    = chipselect && write;
  assign rd_en    = chipselect && read;
  assign clr_cnt  = wr_en && (address == 4'd0) && writedata[1];
  assign push_req = wr_en && (address == 4'd4);
  assign ovf_clr  = wr_en && (address == 4'd5) && writedata[2];

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign gen_valid = !empty && enable_q;
  assign pop       = gen_valid && gen_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);

  assign gen_src  = mem_src[rd_ptr];
  assign gen_dest = mem_dest[rd_ptr];
  assign gen_len  = mem_len[rd_ptr];

  // The 4-bit level field cannot show 16, so it pins at 15 (full flags the rest).
  assign count5 = 5'(count);
  assign level4 = count5[4] ? 4'hF : count5[3:0];

  // Next FIFO occupancy and saturation summary.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + 1'b1;
    else if (!push_ok && pop) count_nxt = count - 1'b1;
    sat_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (cnt_q[i] == 16'hFFFF) sat_any = 1'b1;
  end

  // Staging/control registers, overflow flag and counter snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q  <= 1'b0;
      src_q     <= '0;
      dest_q    <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_sel_q <= '0;
      snap_q    <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          4'd0: enable_q <= writedata[0];
          4'd1: src_q    <= writedata[PORT_W-1:0];
          4'd2: dest_q   <= writedata[PORT_W-1:0];
          4'd3: len_q    <= writedata[LEN_W-1:0];
          4'd6: begin
            cnt_sel_q <= writedata;
            snap_q    <= (int'(writedata) < NUM_PORTS) ? cnt_q[writedata[PORT_W-1:0]] : 16'h0000;
          end
          default: ;
        endcase
      end
      // A dropped push in the same cycle as a clear leaves the flag set.
      if (push_req && !push_ok) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  // Command FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_src[i]  <= '0;
        mem_dest[i] <= '0;
        mem_len[i]  <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_src[wr_ptr]  <= src_q;
        mem_dest[wr_ptr] <= dest_q;
        mem_len[wr_ptr]  <= len_q;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Per-port saturating delivered-packet counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (pkt_done[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

`ifdef SWITCH_CSR_IRQ_EN
  logic [2:0] irq_stat_q, irq_mask_q;

  // Sticky interrupt sources (set beats write-1-clear), mask and registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_en && (address == 4'd10)) irq_mask_q <= writedata[2:0];
      irq_stat_q[0] <= (!empty && (count_nxt == '0)) ||
                       (irq_stat_q[0] && !(wr_en && (address == 4'd9) && writedata[0]));
      irq_stat_q[1] <= (push_req && !push_ok) ||
                       (irq_stat_q[1] && !(wr_en && (address == 4'd9) && writedata[1]));
      irq_stat_q[2] <= sat_any ||
                       (irq_stat_q[2] && !(wr_en && (address == 4'd9) && writedata[2]));
      irq <= |(irq_stat_q & irq_mask_q);
    end
  end
`endif

  // Read data select; unmapped addresses return 0.
  always_comb begin
    rd_mux = 8'h00;
    case (address)
      4'd0: rd_mux = {7'b0, enable_q};
      4'd1: rd_mux = 8'(src_q);
      4'd2: rd_mux = 8'(dest_q);
      4'd3: rd_mux = 8'(len_q);
      4'd5: rd_mux = {level4, 1'b0, ovf_q, full, empty};
      4'd6: rd_mux = cnt_sel_q;
      4'd7: rd_mux = snap_q[7:0];
      4'd8: rd_mux = snap_q[15:8];
`ifdef SWITCH_CSR_IRQ_EN
      4'd9:  rd_mux = {5'b0, irq_stat_q};
      4'd10: rd_mux = {5'b0, irq_mask_q};
`endif
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered read data, held until the next read.
  always_ff @(posedge clk) begin
    if (reset)      readdata <= 8'h00;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_switch_csr_ctrl.sv
// Directed testbench for switch_csr_ctrl (default build, IRQ feature off).
`timescale 1ns/1ps
module tb_switch_csr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       chipselect, write, read;
  logic [3:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       gen_valid, gen_ready;
  logic [1:0] gen_src, gen_dest;
  logic [7:0] gen_len;
  logic [3:0] pkt_done;

  int checks = 0;
  int errors = 0;

  switch_csr_ctrl #(.NUM_PORTS(4), .FIFO_DEPTH(8), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_src(gen_src),
    .gen_dest(gen_dest), .gen_len(gen_len), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  // All tasks are entered and left at a falling edge.
  task automatic csr_write(input logic [3:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic [7:0] exp;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (gen_valid !== 1'b0 || gen_src !== 2'd0 || gen_dest !== 2'd0 || gen_len !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b src=%0d dest=%0d len=%0d, required all 0",
               gen_valid, gen_src, gen_dest, gen_len);
    end
    for (int a = 0; a < 16; a++) begin
      csr_read(4'(a), d);
      exp = (a == 5) ? 8'h01 : 8'h00;
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h, required %h", a, d, exp);
      end
    end
  endtask

  task automatic test_single_cmd;
    logic [7:0] d;
    int beats;
    csr_write(4'd1, 8'd1);
    csr_write(4'd2, 8'd3);
    csr_write(4'd3, 8'd64);
    csr_write(4'd4, 8'h00);
    csr_read(4'd5, d);
    checks++;
    if (d !== 8'h10) begin
      errors++;
      $display("FAIL single_status_one: got %h, required 10", d);
    end
    gen_ready = 1'b1;
    csr_write(4'd0, 8'h01);
    beats = 0;
    repeat (5) begin
      if (gen_valid) begin
        beats++;
        checks++;
        if (gen_src !== 2'd1 || gen_dest !== 2'd3 || gen_len !== 8'd64) begin
          errors++;
          $display("FAIL single_fields: src=%0d dest=%0d len=%0d, required 1 3 64",
                   gen_src, gen_dest, gen_len);
        end
      end
      @(negedge clk);
    end
    gen_ready = 1'b0;
    checks++;
    if (beats != 1) begin
      errors++;
      $display("FAIL single_beats: got %0d, required 1", beats);
    end
    csr_read(4'd5, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL single_status_empty: got %h, required 01", d);
    end
    csr_write(4'd0, 8'h03);
    csr_read(4'd0, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL ctrl_readback: got %h, required 01", d);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    csr_write(4'd0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      csr_write(4'd3, 8'(10 + i));
      csr_write(4'd4, 8'h00);
    end
    csr_read(4'd5, d);
    checks++;
    if (d !== 8'h86) begin
      errors++;
      $display("FAIL overflow_status: got %h, required 86", d);
    end
    csr_write(4'd5, 8'h04);
    csr_read(4'd5, d);
    checks++;
    if (d !== 8'h82) begin
      errors++;
      $display("FAIL overflow_clear: got %h, required 82", d);
    end
    checks++;
    if (gen_valid !== 1'b0) begin
      errors++;
      $display("FAIL disabled_valid: got %b, required 0", gen_valid);
    end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] d;
    gen_ready = 1'b0;
    csr_write(4'd0, 8'h01);
    checks++;
    if (gen_valid !== 1'b1 || gen_len !== 8'd10) begin
      errors++;
      $display("FAIL full_head: valid=%b len=%0d, required 1 10", gen_valid, gen_len);
    end
    gen_ready = 1'b1;
    csr_write(4'd4, 8'h00);
    gen_ready = 1'b0;
    csr_read(4'd5, d);
    checks++;
    if (d !== 8'h82) begin
      errors++;
      $display("FAIL full_push_pop_status: got %h, required 82", d);
    end
    checks++;
    if (gen_len !== 8'd11) begin
      errors++;
      $display("FAIL full_push_pop_head: got %0d, required 11", gen_len);
    end
  endtask

  task automatic test_stall_reset;
    logic [7:0] d;
    gen_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (gen_valid !== 1'b1 || gen_src !== 2'd1 || gen_dest !== 2'd3 || gen_len !== 8'd11) begin
        errors++;
        $display("FAIL stall_hold: valid=%b src=%0d dest=%0d len=%0d, required 1 1 3 11",
                 gen_valid, gen_src, gen_dest, gen_len);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (gen_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_transfer: valid=%b, required 0", gen_valid);
    end
    csr_read(4'd5, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL reset_fifo_dropped: status %h, required 01", d);
    end
  endtask

  task automatic test_counters;
    logic [7:0] d;
    pkt_done = 4'b0110;
    repeat (3) @(negedge clk);
    pkt_done = 4'b0100;
    repeat (69997) @(negedge clk);
    pkt_done = 4'b0000;
    csr_write(4'd6, 8'd2);
    csr_read(4'd7, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL cnt2_lo_sat: got %h, required ff", d);
    end
    csr_read(4'd8, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL cnt2_hi_sat: got %h, required ff", d);
    end
    csr_write(4'd6, 8'd1);
    csr_read(4'd7, d);
    checks++;
    if (d !== 8'h03) begin
      errors++;
      $display("FAIL cnt1_lo: got %h, required 03", d);
    end
    csr_write(4'd6, 8'd7);
    csr_read(4'd7, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL cnt_sel_oob: got %h, required 00", d);
    end
    csr_write(4'd6, 8'd2);
    pkt_done = 4'b0100;
    csr_write(4'd0, 8'h02);
    pkt_done = 4'b0000;
    csr_read(4'd8, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL snapshot_held: got %h, required ff", d);
    end
    csr_write(4'd6, 8'd2);
    csr_read(4'd7, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL clr_beats_inc: got %h, required 00", d);
    end
    csr_read(4'd6, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL cnt_sel_readback: got %h, required 02", d);
    end
  endtask

  task automatic test_unmapped;
    logic [7:0] d;
    csr_write(4'd9, 8'hFF);
    csr_write(4'd12, 8'hFF);
    csr_write(4'd7, 8'hAA);
    csr_read(4'd9, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL unmapped_9: got %h, required 00", d);
    end
    csr_read(4'd7, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL ro_write_ignored: got %h, required 00", d);
    end
    csr_read(4'd5, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL unmapped_side_effect: status %h, required 01", d);
    end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 4'd0; writedata = 8'h00; gen_ready = 1'b0; pkt_done = 4'b0;
    @(negedge clk);
    test_reset();
    test_single_cmd();
    test_overflow();
    test_full_push_pop();
    test_stall_reset();
    test_counters();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
